// File: rtl/rv32i_defs_pkg.sv
// RV32I load/store width codes, LSU FSM state codes and the request legality rule.
package rv32i_defs;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD    = 3'd1;
  localparam logic [2:0] ST_LDATA = 3'd2;
  localparam logic [2:0] ST_MERGE = 3'd3;
  localparam logic [2:0] ST_WR    = 3'd4;

  // Misaligned, beyond the BRAM, or a width code RV32I does not define.
  function automatic logic req_error(logic we, logic [2:0] f3, logic [31:0] addr,
                                     int unsigned depth_log);
    logic e;
    e = ((addr >> (depth_log + 2)) != 32'd0);
    if (we)
      e = e | (f3 > F3_SW) | ((f3 == F3_SH) & addr[0]) |
          ((f3 == F3_SW) & (addr[1:0] != 2'b00));
    else
      e = e | (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111) |
          (((f3 == F3_LH) | (f3 == F3_LHU)) & addr[0]) |
          ((f3 == F3_LW) & (addr[1:0] != 2'b00));
    return e;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_align
  import rv32i_defs::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Pick the addressed lane out of the word and extend it by width code.
  always_comb begin
    byte_v  = rdata[{off, 3'b000} +: 8];
    half_v  = rdata[{off[1], 4'b0000} +: 16];
    ld_data = 32'd0;
    case (funct3)
      F3_LB:   ld_data = {{24{byte_v[7]}}, byte_v};
      F3_LBU:  ld_data = {24'd0, byte_v};
      F3_LH:   ld_data = {{16{half_v[15]}}, half_v};
      F3_LHU:  ld_data = {16'd0, half_v};
      F3_LW:   ld_data = rdata;
      default: ld_data = 32'd0;
    endcase
  end

  // Replace only the addressed lane of the old word; full words pass wdata.
  always_comb begin
    merged = rdata;
    case (funct3)
      F3_SB:   merged[{off, 3'b000} +: 8] = wdata[7:0];
      F3_SH:   merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/bram_lsu.sv
// Load/store unit driving one single-port word-wide BRAM without byte enables.
// Sub-word stores are done as read-modify-write (RD -> MERGE).
module bram_lsu
  import rv32i_defs::*;
#(
  parameter int DEPTH_LOG = 8
) (
  input  logic                 clk,
  input  logic                 resetb,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [DEPTH_LOG-1:0] mem_addr,
  output logic [31:0]          mem_di,
  input  logic [31:0]          mem_do
);

  logic [2:0]           state;
  logic                 we_q;
  logic [2:0]           funct3_q;
  // Address bits above the word index only feed the range check, which is
  // resolved at acceptance, so only the in-range part is kept.
  logic [DEPTH_LOG+1:0] addr_q;
  logic [31:0]          wdata_q;
  logic [31:0]          ld_data;
  logic [31:0]          merged;
  logic                 bad;

  assign req_ready = (state == ST_IDLE);
  assign mem_addr  = addr_q[DEPTH_LOG+1:2];
  assign bad       = req_error(req_we, req_funct3, req_addr, DEPTH_LOG);

  lsu_align u_align (
    .funct3  (funct3_q),
    .off     (addr_q[1:0]),
    .rdata   (mem_do),
    .wdata   (wdata_q),
    .ld_data (ld_data),
    .merged  (merged)
  );

  // FSM, request latch and one-cycle registered response.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state     <= ST_IDLE;
      we_q      <= 1'b0;
      funct3_q  <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr[DEPTH_LOG+1:0];
            wdata_q  <= req_wdata;
            if (bad) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'd0;
            end else if (req_we && req_funct3 == F3_SW) begin
              state <= ST_WR;
            end else begin
              state <= ST_RD;
            end
          end
        end
        ST_RD: state <= we_q ? ST_MERGE : ST_LDATA;
        ST_LDATA: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= ld_data;
          state     <= ST_IDLE;
        end
        ST_MERGE, ST_WR: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'd0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // BRAM strobes come from state and latched request only.
  always_comb begin
    mem_en = 1'b0;
    mem_we = 1'b0;
    mem_di = 32'd0;
    case (state)
      ST_RD:    mem_en = 1'b1;
      ST_LDATA: mem_en = 1'b0;
      ST_MERGE: begin
        mem_en = 1'b1;
        mem_we = 1'b1;
        mem_di = merged;
      end
      ST_WR: begin
        mem_en = 1'b1;
        mem_we = 1'b1;
        mem_di = wdata_q;
      end
      default: mem_en = 1'b0;
    endcase
  end

endmodule
